// File: rtl/ram16_bus_ctrl_if.sv
// Request/response handshake bundle between a requester and the SRAM bus controller.
interface ram16_bus_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram16_bus_ctrl.sv
// Request-side controller for the 16x16 single-port SRAM: turns valid/ready requests
// into registered cs/we/oe/addr strobes and owns the write half of the shared data bus.
module ram16_bus_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ram16_bus_ctrl_if.slave       req_if,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);
    typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_DATA} state_e;

    state_e                state_q;
    logic                  ready_q;
    logic                  rsp_valid_q;
    logic                  cs_q;
    logic                  we_q;
    logic                  oe_q;
    logic                  drive_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: every strobe is a flop set one state ahead, so ram_* never sees a req_* glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            drive_q     <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_if.req_valid) begin
                        addr_q  <= req_if.req_addr;
                        wdata_q <= req_if.req_wdata;
                        ready_q <= 1'b0;
                        cs_q    <= 1'b1;
                        if (req_if.req_we) begin
                            state_q <= WRITE;
                            we_q    <= 1'b1;
                            drive_q <= 1'b1;
                        end else begin
                            state_q <= RD_ADDR;
                        end
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                    cs_q    <= 1'b0;
                    we_q    <= 1'b0;
                    drive_q <= 1'b0;
                    ready_q <= 1'b1;
                end
                RD_ADDR: begin
                    state_q <= RD_DATA;
                    oe_q    <= 1'b1;
                end
                RD_DATA: begin
                    // The SRAM has been driving since oe rose; sample at the closing edge.
                    rdata_q     <= ram_data;
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                    cs_q        <= 1'b0;
                    oe_q        <= 1'b0;
                    ready_q     <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_data         = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign ram_addr         = addr_q;
    assign ram_cs           = cs_q;
    assign ram_we           = we_q;
    assign ram_oe           = oe_q;
    assign req_if.req_ready = ready_q;
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_ram16_bus_ctrl.sv
// Bench for ram16_bus_ctrl: behavioural SRAM on the shared bus, a read-data scoreboard,
// and directed steps covering latency, handshake, bus ownership and reset cases.
module tb_ram16_bus_ctrl;
    logic        clk;
    logic        rst;
    logic [3:0]  ram_addr;
    wire  [15:0] ram_data;
    logic        ram_cs;
    logic        ram_we;
    logic        ram_oe;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    logic [15:0] sb[$];
    logic [15:0] exp_mem [16];

    ram16_bus_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();

    ram16_bus_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_if   (bus.slave),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_oe   (ram_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: write at posedge, capture at negedge, drive while oe is high.
    logic [15:0] mem [16];
    logic [15:0] rd_q;
    always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
    always @(negedge clk) if (ram_cs && !ram_we) rd_q <= mem[ram_addr];
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? rd_q : 16'hzzzz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus-ownership monitor and scoreboard consumer.
    always @(negedge clk) begin
        if (ram_oe) begin
            check("oe_with_we", {31'd0, ram_we}, 32'd0);
            check("oe_data_known", {31'd0, $isunknown(ram_data)}, 32'd0);
        end
        if (bus.rsp_valid) begin
            if (sb.size() == 0) check("rsp_spurious", {31'd0, bus.rsp_valid}, 32'd0);
            else check("rsp_rdata", {16'd0, bus.rsp_rdata}, {16'd0, sb.pop_front()});
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drives a request and returns just after the accepting edge; waits counts ready-low cycles.
    task automatic issue(input logic we, input logic [3:0] addr, input logic [15:0] data,
                         input bit expect_rsp, input bit hold, output int waits);
        bit taken = 1'b0;
        waits = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        for (int i = 0; i < 20 && !taken; i++) begin
            @(negedge clk);
            taken = bus.req_ready;
            if (!taken) waits++;
            @(posedge clk);
            #1;
        end
        check("accept_timeout", {31'd0, taken}, 32'd1);
        if (we) exp_mem[addr] = data;
        else if (expect_rsp) sb.push_back(exp_mem[addr]);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    initial begin
        int w;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) sync();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        check("rst_addr", {28'd0, ram_addr}, 32'd0);
        check("rst_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
        sync();

        // Prefill every location so all later reads have known contents
        for (int a = 0; a < 16; a++) issue(1'b1, 4'(a), 16'(a * 16'h1111) ^ 16'h5A5A, 1'b0, 1'b0, w);

        // Write 0xA5A5 to addr 3: one-cycle write strobe with bus driven
        issue(1'b1, 4'd3, 16'hA5A5, 1'b0, 1'b0, w);
        @(negedge clk);
        check("wr_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'b110);
        check("wr_addr", {28'd0, ram_addr}, 32'd3);
        check("wr_bus", {16'd0, ram_data}, 32'hA5A5);
        check("wr_ready_low", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        check("wr_strobes_end", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
        sync();

        // Read addr 3: rsp_valid only in the cycle after accept+2 edges
        issue(1'b0, 4'd3, 16'h0, 1'b1, 1'b0, w);
        @(negedge clk);
        check("rd_addr_phase", {29'd0, ram_cs, ram_we, ram_oe}, 32'b100);
        check("rd_lat0", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        check("rd_data_phase", {29'd0, ram_cs, ram_we, ram_oe}, 32'b101);
        check("rd_lat1", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        check("rd_lat2", {31'd0, bus.rsp_valid}, 32'd1);
        @(negedge clk);
        check("rd_pulse_end", {31'd0, bus.rsp_valid}, 32'd0);
        sync();

        // Address boundaries
        issue(1'b1, 4'd0, 16'h0001, 1'b0, 1'b0, w);
        issue(1'b1, 4'd15, 16'hFFFF, 1'b0, 1'b0, w);
        issue(1'b0, 4'd0, 16'h0, 1'b1, 1'b0, w);
        issue(1'b0, 4'd15, 16'h0, 1'b1, 1'b0, w);
        repeat (4) sync();

        // Valid held high across alternating write/read
        issue(1'b1, 4'd5, 16'h1234, 1'b0, 1'b1, w);
        check("hold_w1_wait", 32'(w), 32'd0);
        issue(1'b0, 4'd5, 16'h0, 1'b1, 1'b1, w);
        check("hold_r1_wait", 32'(w), 32'd1);
        issue(1'b1, 4'd5, 16'h4321, 1'b0, 1'b1, w);
        check("hold_w2_wait", 32'(w), 32'd2);
        issue(1'b0, 4'd5, 16'h0, 1'b1, 1'b0, w);
        check("hold_r2_wait", 32'(w), 32'd1);
        repeat (4) sync();
        check("hold_drain", 32'(sb.size()), 32'd0);

        // Random traffic under the bus monitor
        for (int n = 0; n < 50; n++) begin
            issue(1'($urandom), 4'($urandom), 16'($urandom), 1'b1, 1'b0, w);
            repeat ($urandom_range(0, 2)) sync();
        end
        repeat (5) sync();
        check("rand_drain", 32'(sb.size()), 32'd0);

        // Reset during RD_ADDR of a read to addr 7
        issue(1'b0, 4'd7, 16'h0, 1'b0, 1'b0, w);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("rrd_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
        check("rrd_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rrd_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rrd_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        sync();

        // Reset during WRITE of 0xBEEF to addr 9; a request held through reset is ignored
        issue(1'b1, 4'd9, 16'hBEEF, 1'b0, 1'b1, w);
        rst = 1'b1;
        bus.req_wdata = 16'h0BAD;
        repeat (2) sync();
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rwr_idle", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
        sync();
        issue(1'b0, 4'd9, 16'h0, 1'b1, 1'b0, w);
        repeat (5) sync();
        check("final_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ram16_bus_ctrl.md
Name: ram16_bus_ctrl

Overview:
- Request-side controller that sits directly upstream of the team's 16-word x 16-bit single-port SRAM macro.
- Turns a valid/ready read/write request stream into the SRAM's cs/we/oe/addr strobes and drives or releases the shared bidirectional data bus.
- Returns read data on a one-cycle response pulse.
- Guarantees no bus contention and meets the SRAM timing: write on posedge; read captured on the negedge, then driven while oe is high.

Parameters:
- ADDR_WIDTH, 4, address bits to SRAM and request port
- DATA_WIDTH, 16, data word width

Ports:
- clk  input  1  system clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  word address
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  one-cycle pulse: rsp_rdata holds read result
- rsp_rdata  output  DATA_WIDTH  read result, held until the next read completes
- ram_addr  output  ADDR_WIDTH  SRAM address
- ram_data  inout  DATA_WIDTH  shared SRAM data bus
- ram_cs  output  1  SRAM chip select
- ram_we  output  1  SRAM write enable
- ram_oe  output  1  SRAM output enable

Behaviour:
- Reset: state IDLE; req_ready=1 in the first cycle after reset; rsp_valid=0; rsp_rdata=0; ram_addr=0; ram_cs/ram_we/ram_oe=0; ram_data released (high-Z).
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA.
- All ram_* strobes and ram_addr decode only from registered state and latched request; no combinational path from req_* to ram_*.
- IDLE:
  - req_ready=1; strobes 0; bus high-Z.
  - On req_valid & req_ready: latch addr, wdata, we.
  - Go to WRITE if we=1, else RD_ADDR.
  - Without req_valid: stay in IDLE.
- WRITE (1 cycle):
  - cs=1, we=1, oe=0; ram_addr=latched addr.
  - ram_data driven with latched wdata; the SRAM stores it at the closing posedge.
  - Then IDLE.
- RD_ADDR (1 cycle):
  - cs=1, we=0, oe=0; bus high-Z; the SRAM captures mem[addr] on the mid-cycle negedge.
  - Then RD_DATA.
- RD_DATA (1 cycle):
  - cs=1, we=0, oe=1; bus high-Z from the controller side.
  - At the closing posedge: rsp_rdata <= ram_data, rsp_valid <= 1.
  - Then IDLE.
- Handshake: req_ready=1 only in IDLE.
  - Request-side inputs are don't-care when req_ready=0; a request held valid is taken on the first cycle back in IDLE.
- Latency:
  - Write accepted at edge N: the SRAM writes at edge N+1.
  - Read accepted at edge N: rsp_valid is high for exactly the cycle after edge N+2.
  - Throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- Contention rules:
  - The controller drives ram_data only while in WRITE.
  - ram_oe is never 1 in the same cycle as ram_we or the controller bus drive.
  - The mandatory IDLE cycle after RD_DATA is the read-to-write turnaround.
- rsp_valid is a single-cycle pulse and never fires for writes.
- Address 0 and address 2^ADDR_WIDTH-1 need no special handling; there is no wrap logic.
- Reset mid-operation (rst high in any state): next state IDLE, strobes 0, bus high-Z, rsp_valid 0, rsp_rdata 0.
  - rst during WRITE does not suppress the SRAM write at that same edge, because strobes were already asserted.
  - rst during RD_ADDR or RD_DATA produces no rsp_valid.
- rst has priority over a simultaneous req_valid: no request is accepted in a reset cycle.

Test Plan:
- Write 0xA5A5 to addr 3, then read addr 3 -> write strobes last 1 cycle with bus=0xA5A5; rsp_valid pulses once, 3 cycles after read accept, with rsp_rdata=0xA5A5.
- Write 0x0001 to addr 0 and 0xFFFF to addr 15, then read both -> rsp_rdata=0x0001, then 0xFFFF; no aliasing.
- req_valid held high with alternating write/read (addr 5, data 0x1234) -> req_ready low in WRITE/RD_ADDR/RD_DATA; each request accepted exactly once; read returns 0x1234.
- Bus monitor across 50 random requests -> never X on ram_data while ram_oe=1; controller drive and ram_oe never overlap; ram_oe never high with ram_we.
- Assert rst in RD_ADDR of a read to addr 7 -> next cycle: IDLE, strobes 0, rsp_valid never pulses, rsp_rdata=0.
- Assert rst in WRITE of 0xBEEF to addr 9, then read addr 9 after reset -> rsp_rdata=0xBEEF.
